// File: rtl/coin_start_seq_if.sv
// Coin/start sequencer port bundle.
// Request inputs from the merge logic, cabinet outputs to the core.
interface coin_start_seq_if;
    logic req_1p;
    logic req_2p;
    logic coin_req;
    logic free_play;
    logic coin_o_n;
    logic start_o_n;
    logic gear_rst;
    logic busy;

    modport master (
        output req_1p, req_2p, coin_req, free_play,
        input  coin_o_n, start_o_n, gear_rst, busy
    );

    modport slave (
        input  req_1p, req_2p, coin_req, free_play,
        output coin_o_n, start_o_n, gear_rst, busy
    );
endinterface

// File: rtl/coin_start_seq.sv
// Coin/start sequencer: turns one player-request press into
// timed coin pulses, a start pulse and a gear-reset strobe.
module coin_start_seq #(
    parameter int COIN_CYC  = 300000,
    parameter int GAP_CYC   = 300000,
    parameter int START_CYC = 600000,
    parameter int HOLD_CYC  = 60000,
    parameter int COINS_1P  = 1,
    parameter int COINS_2P  = 2,
    parameter int CW        = 20
) (
    input  logic       CLK,
    input  logic       reset,
    coin_start_seq_if.slave io
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COIN  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [1:0] M_NONE = 2'd0;
    localparam logic [1:0] M_1P   = 2'd1;
    localparam logic [1:0] M_2P   = 2'd2;
    localparam logic [1:0] M_COIN = 2'd3;

    localparam logic [CW-1:0] T_COIN  = CW'(COIN_CYC - 1);
    localparam logic [CW-1:0] T_GAP   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] T_START = CW'(START_CYC - 1);
    localparam logic [CW-1:0] T_HOLD  = CW'(HOLD_CYC - 1);

    localparam logic [1:0] N_1P = 2'(COINS_1P);
    localparam logic [1:0] N_2P = 2'(COINS_2P);

    // bit 0 = 1P, bit 1 = 2P, bit 2 = coin
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] hist;
    logic [2:0] rise;

    logic [2:0]    state;
    logic [2:0]    nxt;
    logic [1:0]    mode;
    logic [1:0]    nxt_mode;
    logic [1:0]    ncoin;
    logic [1:0]    nxt_ncoin;
    logic [CW-1:0] timer;
    logic [CW-1:0] tload;
    logic          expired;

    assign rise    = s2 & ~hist;
    assign expired = (timer == '0);

    // Two-flop synchroniser plus history for edge detection
    always_ff @(posedge CLK) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            hist <= '0;
        end else begin
            s1   <= {io.coin_req, io.req_2p, io.req_1p};
            s2   <= s1;
            hist <= s2;
        end
    end

    // Next-state, mode and coin-count selection
    always_comb begin
        nxt       = state;
        nxt_mode  = mode;
        nxt_ncoin = ncoin;
        unique case (state)
            S_IDLE: begin
                if (rise[1]) begin
                    nxt_mode  = M_2P;
                    nxt_ncoin = N_2P;
                    nxt       = io.free_play ? S_START : S_COIN;
                end else if (rise[0]) begin
                    nxt_mode  = M_1P;
                    nxt_ncoin = N_1P;
                    nxt       = io.free_play ? S_START : S_COIN;
                end else if (rise[2]) begin
                    nxt_mode  = M_COIN;
                    nxt_ncoin = 2'd1;
                    nxt       = S_COIN;
                end
            end
            S_COIN: begin
                if (expired) begin
                    nxt       = S_GAP;
                    nxt_ncoin = ncoin - 2'd1;
                end
            end
            S_GAP: begin
                if (expired) begin
                    if (ncoin != 2'd0)
                        nxt = S_COIN;
                    else if (mode == M_COIN)
                        nxt = S_HOLD;
                    else
                        nxt = S_START;
                end
            end
            S_START: begin
                if (expired)
                    nxt = S_HOLD;
            end
            S_HOLD: begin
                if (expired && (s2 == 3'd0))
                    nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Duration to load when entering the next state
    always_comb begin
        tload = '0;
        unique case (nxt)
            S_COIN:  tload = T_COIN;
            S_GAP:   tload = T_GAP;
            S_START: tload = T_START;
            S_HOLD:  tload = T_HOLD;
            default: tload = '0;
        endcase
    end

    // State, mode, coin count and down-counter
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= S_IDLE;
            mode  <= M_NONE;
            ncoin <= 2'd0;
            timer <= '0;
        end else begin
            state <= nxt;
            mode  <= nxt_mode;
            ncoin <= nxt_ncoin;
            if (nxt != state)
                timer <= tload;
            else if (timer != '0)
                timer <= timer - CW'(1);
        end
    end

    // Outputs decoded from the next state so they move with it
    always_ff @(posedge CLK) begin
        if (reset) begin
            io.coin_o_n  <= 1'b1;
            io.start_o_n <= 1'b1;
            io.gear_rst  <= 1'b0;
            io.busy      <= 1'b0;
        end else begin
            io.coin_o_n  <= (nxt != S_COIN);
            io.start_o_n <= (nxt != S_START);
            io.gear_rst  <= (nxt == S_START) && (state != S_START);
            io.busy      <= (nxt != S_IDLE);
        end
    end

endmodule
